// File: rtl/stream_extreme_pkg.sv
// Shared mode and state encodings for the signed stream extreme reducer.
package stream_extreme_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_extreme_sint_cmp_sel.sv
// Signed strict-win test: take_b is high when b beats a for the given mode.
module sint_cmp_sel
    import stream_extreme_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    mode,
    output logic                    take_b
);

    // Strict comparison only, so ties always keep the earlier operand.
    assign take_b = (mode == MODE_MIN) ? (b < a) : (b > a);

endmodule

// File: rtl/stream_extreme_sint.sv
// Reduces a valid/ready stream of signed operands to its max or min,
// reporting the winner's position, the group length and an overflow flag.
module stream_extreme_sint
    import stream_extreme_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic [IDX_W:0]          out_count,
    output logic                    out_overflow
);

    localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};

    state_t                  state_q;
    logic signed [WIDTH-1:0] acc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W:0]          cnt_q;
    logic                    ovf_q;
    logic                    mode_q;
    logic                    out_valid_q;

    logic                    take_b;
    logic                    cnt_sat;
    logic [IDX_W:0]          cnt_d;
    logic [IDX_W-1:0]        idx_d;

    sint_cmp_sel #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a      (acc_q),
        .b      (in_data),
        .mode   (mode_q),
        .take_b (take_b)
    );

    // Once the count saturates, further winners report the all-ones index.
    assign cnt_sat = (cnt_q == CNT_MAX);
    assign cnt_d   = cnt_sat ? cnt_q : cnt_q + 1'b1;
    assign idx_d   = cnt_sat ? {IDX_W{1'b1}} : cnt_q[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= MODE_MAX;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q  <= in_data;
                        idx_q  <= '0;
                        cnt_q  <= {{IDX_W{1'b0}}, 1'b1};
                        ovf_q  <= 1'b0;
                        mode_q <= mode;
                        if (in_last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (take_b) begin
                            acc_q <= in_data;
                            idx_q <= idx_d;
                        end
                        cnt_q <= cnt_d;
                        if (cnt_sat) begin
                            ovf_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = (state_q != DONE);
    assign out_valid    = out_valid_q;
    assign out_data     = acc_q;
    assign out_index    = idx_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_stream_extreme_sint.sv
// Scoreboard bench: stimulus queues expected results, monitors check them on output beats.
module tb_stream_extreme_sint;

    typedef struct {
        int d;
        int i;
        int c;
        int o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic in_last = 1'b0;
    logic mode = 1'b0;
    logic out_ready = 1'b0;
    bit   sel2 = 1'b0;
    bit   rnd_en = 1'b0;
    bit   rnd_gap = 1'b0;

    logic iv1, ir1, ov1, ovf1;
    logic signed [15:0] od1;
    logic [7:0] oi1;
    logic [8:0] oc1;

    logic iv2, ir2, ov2, ovf2;
    logic signed [15:0] od2;
    logic [1:0] oi2;
    logic [2:0] oc2;

    logic ir;

    exp_t q1[$];
    exp_t q2[$];
    int n_tests = 0;
    int n_fail = 0;

    assign iv1 = sel2 ? 1'b0 : in_valid;
    assign iv2 = sel2 ? in_valid : 1'b0;
    assign ir  = sel2 ? ir2 : ir1;

    always #5 clk = ~clk;

    stream_extreme_sint #(.WIDTH(16), .IDX_W(8)) dut1 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_index(oi1), .out_count(oc1), .out_overflow(ovf1)
    );

    stream_extreme_sint #(.WIDTH(16), .IDX_W(2)) dut2 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_index(oi2), .out_count(oc2), .out_overflow(ovf2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected result", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1 out_data", od1, e.d);
                chk("dut1 out_index", int'(oi1), e.i);
                chk("dut1 out_count", int'(oc1), e.c);
                chk("dut1 out_overflow", int'(ovf1), e.o);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && ov2 && out_ready) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected result", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("dut2 out_data", od2, e.d);
                chk("dut2 out_index", int'(oi2), e.i);
                chk("dut2 out_count", int'(oc2), e.c);
                chk("dut2 out_overflow", int'(ovf2), e.o);
            end
        end
    end

    // Called and returns at a falling edge.
    task automatic send_beat(input int d, input bit last, input bit m);
        int b;
        in_valid = 1'b1;
        in_data  = 16'(d);
        in_last  = last;
        mode     = m;
        b = 0;
        while (!ir && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!ir) begin
            chk("in_ready timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) chk(sel2 ? "dut2 out_valid latency" : "dut1 out_valid latency",
                      sel2 ? int'(ov2) : int'(ov1), 1);
    endtask

    task automatic run_group(input int vals[$], input bit m, input bit flip,
                             input int ed, input int ei, input int ec, input int eo);
        exp_t e;
        e.d = ed; e.i = ei; e.c = ec; e.o = eo;
        if (sel2) q2.push_back(e);
        else q1.push_back(e);
        for (int k = 0; k < vals.size(); k++) begin
            if (rnd_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(vals[k], k == vals.size() - 1, (k == 0) ? m : (flip ? ~m : m));
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((q1.size() != 0 || q2.size() != 0) && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("drain timeout", q1.size() + q2.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, int'(ov1), 0);
        chk({tag, " in_ready"}, int'(ir1), 1);
        chk({tag, " out_data"}, od1, 0);
        chk({tag, " out_index"}, int'(oi1), 0);
        chk({tag, " out_count"}, int'(oc1), 0);
        chk({tag, " out_overflow"}, int'(ovf1), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[$];
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        chk("reset dut2 out_valid", int'(ov2), 0);
        chk("reset dut2 in_ready", int'(ir2), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed groups on the wide instance, back to back, ready always high.
        out_ready = 1'b1;
        v = {-3, 7, 7, -100};            run_group(v, 1'b0, 1'b0, 7, 1, 4, 0);
        v = {-32768};                    run_group(v, 1'b1, 1'b0, -32768, 0, 1, 0);
        v = {32767, -32768, 32767};      run_group(v, 1'b0, 1'b0, 32767, 0, 3, 0);
        drain();

        // Same style of vectors with random input gaps and output stalls.
        rnd_en = 1'b1;
        rnd_gap = 1'b1;
        v = {0, -1, -1, 5};              run_group(v, 1'b1, 1'b0, -1, 1, 4, 0);
        v = {100, 50, 50, -32768, -32768}; run_group(v, 1'b1, 1'b0, -32768, 3, 5, 0);
        v = {-32768, -32768};            run_group(v, 1'b0, 1'b0, -32768, 0, 2, 0);
        v = {-1, -2, 0};                 run_group(v, 1'b0, 1'b0, 0, 2, 3, 0);
        v = {1, 5, 3};                   run_group(v, 1'b0, 1'b1, 5, 1, 3, 0);
        v = {1, 5, -3};                  run_group(v, 1'b1, 1'b1, -3, 2, 3, 0);
        drain();

        // Backpressure: hold the result for ten cycles.
        rnd_en = 1'b0;
        rnd_gap = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        v = {10, -20, 30};               run_group(v, 1'b0, 1'b0, 30, 2, 3, 0);
        for (int k = 0; k < 10; k++) begin
            chk("bp out_valid", int'(ov1), 1);
            chk("bp in_ready", int'(ir1), 0);
            chk("bp out_data", od1, 30);
            chk("bp out_index", int'(oi1), 2);
            chk("bp out_count", int'(oc1), 3);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp release out_valid", int'(ov1), 0);
        chk("bp release in_ready", int'(ir1), 1);
        v = {4};                         run_group(v, 1'b0, 1'b0, 4, 0, 1, 0);
        drain();

        // Reset in the middle of a group discards it.
        send_beat(32767, 1'b0, 1'b0);
        send_beat(1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_state("mid-group reset");
        v = {-5};                        run_group(v, 1'b0, 1'b0, -5, 0, 1, 0);
        drain();

        // Narrow-index instance: count saturation and overflow.
        sel2 = 1'b1;
        @(negedge clk);
        v = {1, 2, 3, 4, 9};             run_group(v, 1'b0, 1'b0, 9, 3, 4, 1);
        v = {1, 1, 1, 1};                run_group(v, 1'b1, 1'b0, 1, 0, 4, 0);
        v = {9, 1, 2, 3, 4, 5};          run_group(v, 1'b0, 1'b0, 9, 0, 4, 1);
        rnd_en = 1'b1;
        v = {2, -1};                     run_group(v, 1'b0, 1'b0, 2, 0, 2, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
